// File: rtl/icache_axi_master_pkg.sv
// Shared definitions for the instruction-cache AXI read master: bus widths,
// fixed AXI read-address attributes, the OKAY response code and the
// controller state encoding.
package icache_axi_master_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 4;
    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;
    localparam int TYPE_W  = 3;

    // Every fetch is a single 32-bit beat with ID 0 and an INCR burst type
    localparam logic [ID_W-1:0]    AXI_ID    = 4'd0;
    localparam logic [LEN_W-1:0]   AXI_LEN   = 4'd0;
    localparam logic [SIZE_W-1:0]  AXI_SIZE  = 3'b010;
    localparam logic [BURST_W-1:0] AXI_BURST = 2'b01;
    localparam logic [RESP_W-1:0]  RESP_OKAY = 2'b00;

    // Controller states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADDR = 2'd1;
    localparam state_t ST_DATA = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // True when a read response reports anything other than OKAY
    function automatic logic resp_is_error(input logic [RESP_W-1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/icache_axi_master.sv
// Instruction-cache side read master. Turns a single-word cache read request
// into one single-beat AXI read (AR then R) and hands the returned word back
// with a one-cycle completion strobe (I_wait low). Writes are not supported
// and complete immediately with an error.
module icache_axi_master
    import icache_axi_master_pkg::*;
(
    input  logic               clk,
    input  logic               rst,

    input  logic               I_req,
    input  logic [ADDR_W-1:0]  I_addr,
    input  logic               I_write,
    input  logic [DATA_W-1:0]  I_in,
    input  logic [TYPE_W-1:0]  I_type,
    output logic [DATA_W-1:0]  I_out,
    output logic               I_wait,
    output logic               I_err,

    output logic [ID_W-1:0]    ARID_M,
    output logic [ADDR_W-1:0]  ARADDR_M,
    output logic [LEN_W-1:0]   ARLEN_M,
    output logic [SIZE_W-1:0]  ARSIZE_M,
    output logic [BURST_W-1:0] ARBURST_M,
    output logic               ARVALID_M,
    input  logic               ARREADY_M,

    input  logic [ID_W-1:0]    RID_M,
    input  logic [DATA_W-1:0]  RDATA_M,
    input  logic [RESP_W-1:0]  RRESP_M,
    input  logic               RLAST_M,
    input  logic               RVALID_M,
    output logic               RREADY_M
);

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic               err_q;

    // Write data, access type, read ID and last flag play no role in a
    // single-beat read-only master
    logic               unused_inputs;
    assign unused_inputs = ^{I_in, I_type, RID_M, RLAST_M};

    // Next-state decode: requests only start from IDLE, each handshake
    // advances one step, DONE always returns to IDLE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (I_req) begin
                    state_next = I_write ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ARREADY_M) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (RVALID_M) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any transfer in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Address register: captured once in IDLE so ARADDR_M stays stable
    // for as long as ARVALID_M is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (state == ST_IDLE && I_req && !I_write) begin
            addr_q <= I_addr;
        end
    end

    // Returned word and error flag: loaded from the R beat, or forced to
    // zero/error for an unsupported write request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (I_req && I_write) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end else if (I_req) begin
                        err_q  <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (RVALID_M) begin
                        data_q <= RDATA_M;
                        err_q  <= resp_is_error(RRESP_M);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ARID_M    = AXI_ID;
    assign ARLEN_M   = AXI_LEN;
    assign ARSIZE_M  = AXI_SIZE;
    assign ARBURST_M = AXI_BURST;
    assign ARADDR_M  = addr_q;
    assign ARVALID_M = (state == ST_ADDR);
    assign RREADY_M  = (state == ST_DATA);

    assign I_out  = data_q;
    assign I_wait = (state != ST_DONE);
    assign I_err  = (state == ST_DONE) && err_q;

endmodule

// File: tb/tb_icache_axi_master.sv
// Randomized bench for icache_axi_master. The bench plays the AXI slave with
// random handshake delays and predicts, per transaction, the exact cycle of
// every handshake and of the completion strobe plus the returned word/error.
module tb_icache_axi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        I_req;
    logic [31:0] I_addr;
    logic        I_write;
    logic [31:0] I_in;
    logic [2:0]  I_type;
    logic [31:0] I_out;
    logic        I_wait;
    logic        I_err;
    logic [3:0]  ARID_M;
    logic [31:0] ARADDR_M;
    logic [3:0]  ARLEN_M;
    logic [2:0]  ARSIZE_M;
    logic [1:0]  ARBURST_M;
    logic        ARVALID_M;
    logic        ARREADY_M;
    logic [3:0]  RID_M;
    logic [31:0] RDATA_M;
    logic [1:0]  RRESP_M;
    logic        RLAST_M;
    logic        RVALID_M;
    logic        RREADY_M;

    int checkCount = 0;
    int failCount  = 0;

    icache_axi_master dut (
        .clk       (clk),
        .rst       (rst),
        .I_req     (I_req),
        .I_addr    (I_addr),
        .I_write   (I_write),
        .I_in      (I_in),
        .I_type    (I_type),
        .I_out     (I_out),
        .I_wait    (I_wait),
        .I_err     (I_err),
        .ARID_M    (ARID_M),
        .ARADDR_M  (ARADDR_M),
        .ARLEN_M   (ARLEN_M),
        .ARSIZE_M  (ARSIZE_M),
        .ARBURST_M (ARBURST_M),
        .ARVALID_M (ARVALID_M),
        .ARREADY_M (ARREADY_M),
        .RID_M     (RID_M),
        .RDATA_M   (RDATA_M),
        .RRESP_M   (RRESP_M),
        .RLAST_M   (RLAST_M),
        .RVALID_M  (RVALID_M),
        .RREADY_M  (RREADY_M)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Fixed AR attributes are checked whenever a read address is presented
    task automatic checkArConstants();
        checkOutput("arid", ARID_M, 32'd0);
        checkOutput("arlen", ARLEN_M, 32'd0);
        checkOutput("arsize", ARSIZE_M, 32'd2);
        checkOutput("arburst", ARBURST_M, 32'd1);
    endtask

    // One read transaction, entered at the falling edge of an idle cycle.
    // The slave accepts the address after arDelay wait cycles and returns the
    // beat after rDelay wait cycles, so the completion strobe is expected
    // exactly 3 + arDelay + rDelay cycles after the request cycle. With
    // holdReq the cache keeps I_req high with junk inputs while busy.
    task automatic applyStimulus(input logic [31:0] addr, input int arDelay, input int rDelay,
                                 input logic [31:0] data, input logic [1:0] resp,
                                 input bit holdReq);
        I_req   = 1'b1;
        I_addr  = addr;
        I_write = 1'b0;
        I_in    = $urandom;
        I_type  = 3'($urandom);
        @(negedge clk);
        for (int c = 0; c <= arDelay; c++) begin
            if (holdReq) begin
                I_addr  = $urandom;
                I_write = 1'($urandom);
            end else begin
                I_req = 1'b0;
            end
            ARREADY_M = (c == arDelay);
            RVALID_M  = 1'($urandom);
            RDATA_M   = $urandom;
            RRESP_M   = 2'($urandom);
            RID_M     = 4'($urandom);
            RLAST_M   = 1'($urandom);
            checkOutput("arvalid_held", ARVALID_M, 32'd1);
            checkOutput("araddr_stable", ARADDR_M, addr);
            checkOutput("rready_in_addr", RREADY_M, 32'd0);
            checkOutput("wait_in_addr", I_wait, 32'd1);
            checkOutput("err_in_addr", I_err, 32'd0);
            checkArConstants();
            @(negedge clk);
        end
        ARREADY_M = 1'b0;
        for (int c = 0; c <= rDelay; c++) begin
            if (holdReq) begin
                I_addr  = $urandom;
                I_write = 1'($urandom);
            end
            ARREADY_M = 1'($urandom);
            RVALID_M  = (c == rDelay);
            RDATA_M   = (c == rDelay) ? data : $urandom;
            RRESP_M   = (c == rDelay) ? resp : 2'($urandom);
            RID_M     = 4'($urandom);
            RLAST_M   = 1'($urandom);
            checkOutput("arvalid_in_data", ARVALID_M, 32'd0);
            checkOutput("rready_in_data", RREADY_M, 32'd1);
            checkOutput("wait_in_data", I_wait, 32'd1);
            @(negedge clk);
        end
        RVALID_M  = 1'b0;
        ARREADY_M = 1'b0;
        RDATA_M   = $urandom;
        checkOutput("done_wait", I_wait, 32'd0);
        checkOutput("done_data", I_out, data);
        checkOutput("done_err", I_err, {31'd0, resp != 2'b00});
        checkOutput("done_arvalid", ARVALID_M, 32'd0);
        checkOutput("done_rready", RREADY_M, 32'd0);
        @(negedge clk);
        if (!holdReq) begin
            I_req   = 1'b0;
            I_write = 1'b0;
        end
        checkOutput("idle_wait", I_wait, 32'd1);
        checkOutput("idle_err", I_err, 32'd0);
        checkOutput("idle_arvalid", ARVALID_M, 32'd0);
    endtask

    // Unsupported write: completes in the very next cycle with zero data and
    // an error, without touching the AXI read channel
    task automatic applyWrite(input logic [31:0] addr);
        I_req   = 1'b1;
        I_write = 1'b1;
        I_addr  = addr;
        I_in    = $urandom;
        @(negedge clk);
        I_req   = 1'b0;
        I_write = 1'b0;
        checkOutput("wr_wait", I_wait, 32'd0);
        checkOutput("wr_err", I_err, 32'd1);
        checkOutput("wr_out", I_out, 32'd0);
        checkOutput("wr_arvalid", ARVALID_M, 32'd0);
        @(negedge clk);
        checkOutput("wr_idle_wait", I_wait, 32'd1);
        checkOutput("wr_idle_err", I_err, 32'd0);
        checkOutput("wr_idle_arvalid", ARVALID_M, 32'd0);
    endtask

    // Watchdog so the run always ends even if the bench itself stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized transaction stream
    initial begin
        rst       = 1'b1;
        I_req     = 1'b0;
        I_addr    = '0;
        I_write   = 1'b0;
        I_in      = '0;
        I_type    = '0;
        ARREADY_M = 1'b0;
        RID_M     = '0;
        RDATA_M   = '0;
        RRESP_M   = '0;
        RLAST_M   = 1'b0;
        RVALID_M  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_wait", I_wait, 32'd1);
        checkOutput("rst_err", I_err, 32'd0);
        checkOutput("rst_out", I_out, 32'd0);
        checkOutput("rst_arvalid", ARVALID_M, 32'd0);
        checkOutput("rst_rready", RREADY_M, 32'd0);
        checkOutput("rst_araddr", ARADDR_M, 32'd0);

        // Request presented together with reset release, minimum latency
        rst = 1'b0;
        applyStimulus(32'h0000_1004, 0, 0, 32'hDEAD_BEEF, 2'b00, 1'b0);

        // Slow address acceptance
        applyStimulus(32'h0000_2000, 5, 1, $urandom, 2'b00, 1'b0);

        // Error response still returns the data word
        applyStimulus(32'h0000_3000, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      32'h1234_5678, 2'b10, 1'b0);

        applyWrite(32'h0000_4000);

        // Four sequential reads with the request held high between them
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h0000_0100 + 32'(i * 4), int'($urandom_range(0, 4)),
                          int'($urandom_range(0, 4)), $urandom, 2'b00, i != 3);
        end

        // Reset while waiting for read data
        I_req  = 1'b1;
        I_addr = 32'h0000_5000;
        @(negedge clk);
        I_req     = 1'b0;
        ARREADY_M = 1'b1;
        checkOutput("pre_rst_arvalid", ARVALID_M, 32'd1);
        @(negedge clk);
        ARREADY_M = 1'b0;
        checkOutput("pre_rst_rready", RREADY_M, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_arvalid", ARVALID_M, 32'd0);
        checkOutput("midrst_rready", RREADY_M, 32'd0);
        checkOutput("midrst_wait", I_wait, 32'd1);
        checkOutput("midrst_err", I_err, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'h0000_6008, 1, 2, $urandom, 2'b00, 1'b0);

        // Random stream of reads and occasional writes
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                applyWrite($urandom);
            end else begin
                applyStimulus($urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                              $urandom, 2'($urandom), (i != 23) && ($urandom_range(0, 1) == 1));
            end
        end
        I_req   = 1'b0;
        I_write = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("final_wait", I_wait, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/icache_axi_master.md
ICACHE_AXI_MASTER -- requirements
Module: icache_axi_master

Interface
REQ-001 SHALL have ports: clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-002 SHALL have cache-side inputs: I_req in 1, word read request; I_addr in 32, byte address; I_write in 1, write request (unsupported); I_in in 32, write data (ignored); I_type in 3, access type (ignored).
REQ-003 SHALL have cache-side outputs: I_out out 32, returned word; I_wait out 1, low only in the cycle I_out is valid; I_err out 1, one-cycle error flag.
REQ-004 SHALL have AXI AR outputs: ARID_M 4, ARADDR_M 32, ARLEN_M 4, ARSIZE_M 3, ARBURST_M 2, ARVALID_M 1; input ARREADY_M 1.
REQ-005 SHALL have AXI R inputs: RID_M 4, RDATA_M 32, RRESP_M 2, RLAST_M 1, RVALID_M 1; output RREADY_M 1.
REQ-006 Constants SHALL be: ARID_M = 4'd0, ARLEN_M = 4'd0 (single beat), ARSIZE_M = 3'b010, ARBURST_M = 2'b01 (INCR).

Function
REQ-007 FSM SHALL have states IDLE, ADDR, DATA, DONE.
REQ-008 IDLE: I_req=1 and I_write=0 -> register I_addr, go to ADDR; I_req=1 and I_write=1 -> go to DONE with I_out=0 and I_err=1; otherwise stay.
REQ-009 ADDR: ARVALID_M=1, ARADDR_M=registered address; ARREADY_M=1 -> DATA; else stay.
REQ-010 ARVALID_M SHALL stay high, with ARADDR_M stable, until ARREADY_M is sampled high; no withdrawal.
REQ-011 DATA: RREADY_M=1; RVALID_M=1 -> capture RDATA_M into I_out register, go to DONE; else stay.
REQ-012 DONE: I_wait=0, I_out holds captured word; unconditionally -> IDLE next cycle.
REQ-013 I_wait SHALL be 1 in IDLE, ADDR and DATA, and 0 only in DONE.
REQ-014 I_err SHALL be 1 in DONE iff captured RRESP_M != 2'b00 or the request was a write; otherwise 0.
REQ-015 RID_M and RLAST_M SHALL not be checked; every R beat in DATA ends the transaction.
REQ-016 Cache-side inputs SHALL be sampled only in IDLE; changes in other states SHALL have no effect.
REQ-017 RVALID_M outside DATA SHALL be ignored; RREADY_M SHALL be 0 outside DATA.
REQ-018 Minimum latency: I_req at cycle 0, ARREADY_M=1 at cycle 1, RVALID_M=1 at cycle 2 -> I_wait=0 with data at cycle 3.
REQ-019 Back-to-back: I_req held high through DONE SHALL start a new request in the IDLE cycle that follows, one idle cycle minimum between transactions.
REQ-020 At most one outstanding AXI transaction SHALL exist at any time.

Reset
REQ-021 On rst: state=IDLE, ARVALID_M=0, RREADY_M=0, I_wait=1, I_err=0, I_out=0, ARADDR_M=0.
REQ-022 Reset mid-transaction SHALL abandon the transfer immediately, with no completion pulse after release.
REQ-023 The first request SHALL be accepted in the first rising edge after rst deasserts.

Structure
REQ-024 Shared package SHALL hold the state enum, the AXI constants (ID, LEN, SIZE, BURST, RESP_OKAY) and the width parameters.
REQ-025 No sub-module SHALL exist: one FSM, the address/data/error registers and output decode.

Verification
REQ-026 I_req=1, I_addr=0x0000_1004; ARREADY_M=1 immediately; RVALID_M=1, RDATA_M=0xDEAD_BEEF next cycle -> ARADDR_M=0x0000_1004, I_out=0xDEAD_BEEF with I_wait=0 at cycle 3, I_err=0.
REQ-027 ARREADY_M held 0 for 5 cycles -> ARVALID_M high and ARADDR_M stable all 5 cycles, handshake on cycle 6, I_wait stays 1 until DONE.
REQ-028 RRESP_M=2'b10 with RDATA_M=0x1234_5678 -> I_out=0x1234_5678, I_err=1 for exactly one cycle with I_wait=0.
REQ-029 I_req=1, I_write=1 in IDLE -> no ARVALID_M, DONE next cycle with I_out=0, I_err=1.
REQ-030 Four sequential reads at 0x100, 0x104, 0x108, 0x10C with random ready/valid delays -> four DONE pulses with matching data, in order.
REQ-031 rst asserted while in DATA -> ARVALID_M=0, RREADY_M=0, I_wait=1 immediately; a new read after release completes normally.
